// File: rtl/dff_pipeline.sv
// dff_pipeline: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Each stage carries a valid bit. Bubbles collapse toward the output,
// so an empty stage still fills while the output end is stalled.
// Provides a synchronous flush and a registered occupancy count.
module dff_pipeline #(
   parameter int                 WIDTH     = 8,
   parameter int                 DEPTH     = 3,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0,
   localparam int                CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [CW-1:0]    r_count;

   logic [DEPTH-1:0] w_mv;
   logic [DEPTH-1:0] w_load;
   logic [WIDTH-1:0] w_src [DEPTH];
   logic             w_accept;
   logic             w_emit;
   logic [CW-1:0]    w_count_next;

   // Stage-advance chain, evaluated from the output end back toward stage 0.
   always_comb begin
      logic move_down;
      // NOTE: every combinational output gets a default before any branch or
      // loop, so no path leaves it unassigned and no latch is inferred.
      w_mv      = '0;
      move_down = r_valid[DEPTH-1] & out_ready;
      w_mv[DEPTH-1] = move_down;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         move_down = r_valid[i] & (~r_valid[i+1] | move_down);
         w_mv[i]   = move_down;
      end
   end

   // Handshakes: input is blocked while in reset or flushing.
   always_comb begin
      in_ready     = rest & ~flush & (~r_valid[0] | w_mv[0]);
      w_accept     = in_valid & in_ready;
      w_emit       = r_valid[DEPTH-1] & out_ready;
      w_count_next = r_count + CW'(w_accept) - CW'(w_emit);
   end

   // Per-stage load enable and data source: stage 0 takes d, stage i takes stage i-1.
   always_comb begin
      w_load    = '0;
      w_load[0] = w_accept;
      w_src[0]  = d;
      for (int i = 1; i < DEPTH; i++) begin
         w_load[i] = w_mv[i-1];
         w_src[i]  = r_data[i-1];
      end
   end

   // Stage registers and occupancy count; flush mirrors the reset state.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         // NOTE: the data registers are reset too (not only the valid bits),
         // so q never shows X after reset even though invalid data is don't-care.
         for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
         r_valid <= '0;
         r_count <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) r_data[i] <= RESET_VAL;
         r_valid <= '0;
         r_count <= '0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the pre-edge
         // values of its neighbour, which is what lets all stages shift at once.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_load[i]) r_data[i] <= w_src[i];
            r_valid[i] <= w_load[i] | (r_valid[i] & ~w_mv[i]);
         end
         r_count <= w_count_next;
      end
   end

   assign out_valid = r_valid[DEPTH-1];
   assign q         = r_data[DEPTH-1];
   assign count     = r_count;

endmodule

// File: tb/tb_dff_pipeline.sv
// tb_dff_pipeline: directed test of dff_pipeline (WIDTH=8, DEPTH=3).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge. Expected values are hand-derived from the cycle-level behaviour.
module tb_dff_pipeline;

   logic       clk = 1'b0;
   logic       rest;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] d;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] q;
   logic [1:0] count;

   int checks   = 0;
   int failures = 0;

   dff_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut (
      .clk       (clk),
      .rest      (rest),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q         (q),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs just after the rising edge, then wait for the falling edge.
   task automatic drive(input logic iv, input logic [7:0] dd, input logic ordy);
      @(posedge clk);
      #1;
      flush     = 1'b0;
      in_valid  = iv;
      d         = dd;
      out_ready = ordy;
      @(negedge clk);
   endtask

   initial begin
      rest = 1'b0; flush = 1'b0; in_valid = 1'b0; d = 8'h00; out_ready = 1'b0;

      // 1. Reset / idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_q", q, 8'h00);
      @(posedge clk);
      #1 rest = 1'b1;
      @(negedge clk);
      check("idle_q", q, 8'h00);
      check("idle_out_valid", out_valid, 0);
      check("idle_count", count, 0);
      check("idle_in_ready", in_ready, 1);

      // 2. Latency: A5 accepted at cycle 0 appears at cycle 3
      drive(1'b1, 8'hA5, 1'b1);
      check("lat_in_ready", in_ready, 1);
      drive(1'b0, 8'h00, 1'b1);
      check("lat_c1_count", count, 1);
      check("lat_c1_ov", out_valid, 0);
      drive(1'b0, 8'h00, 1'b1);
      check("lat_c2_count", count, 1);
      check("lat_c2_ov", out_valid, 0);
      drive(1'b0, 8'h00, 1'b1);
      check("lat_c3_ov", out_valid, 1);
      check("lat_c3_q", q, 8'hA5);
      check("lat_c3_count", count, 1);
      drive(1'b0, 8'h00, 1'b1);
      check("lat_c4_ov", out_valid, 0);
      check("lat_c4_count", count, 0);

      // 3. Streaming 01..0A at one item per cycle
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 8'(k + 1), 1'b1);
         check("str_in_ready", in_ready, 1);
         if (k >= 3) begin
            check("str_ov", out_valid, 1);
            check("str_q", q, k - 2);
            check("str_count", count, 3);
         end
      end
      for (int k = 10; k < 13; k++) begin
         drive(1'b0, 8'h00, 1'b1);
         check("str_tail_ov", out_valid, 1);
         check("str_tail_q", q, k - 2);
      end
      drive(1'b0, 8'h00, 1'b1);
      check("str_end_ov", out_valid, 0);
      check("str_end_count", count, 0);

      // 4. Backpressure and bubble collapse
      drive(1'b1, 8'h11, 1'b0);
      check("bp_c0_in_ready", in_ready, 1);
      drive(1'b1, 8'h22, 1'b0);
      check("bp_c1_in_ready", in_ready, 1);
      check("bp_c1_count", count, 1);
      drive(1'b1, 8'h33, 1'b0);
      check("bp_c2_in_ready", in_ready, 1);
      check("bp_c2_count", count, 2);
      drive(1'b1, 8'h44, 1'b0);
      check("bp_full_in_ready", in_ready, 0);
      check("bp_full_count", count, 3);
      check("bp_full_q", q, 8'h11);
      check("bp_full_ov", out_valid, 1);
      drive(1'b1, 8'h44, 1'b0);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_q", q, 8'h11);
      drive(1'b1, 8'h44, 1'b1);
      check("bp_release_in_ready", in_ready, 1);
      check("bp_release_q", q, 8'h11);
      drive(1'b0, 8'h00, 1'b1);
      check("bp_d22_q", q, 8'h22);
      check("bp_d22_count", count, 3);
      drive(1'b0, 8'h00, 1'b1);
      check("bp_d33_q", q, 8'h33);
      check("bp_d33_count", count, 2);
      drive(1'b0, 8'h00, 1'b1);
      check("bp_d44_q", q, 8'h44);
      check("bp_d44_ov", out_valid, 1);
      check("bp_d44_count", count, 1);
      drive(1'b0, 8'h00, 1'b1);
      check("bp_empty_ov", out_valid, 0);
      check("bp_empty_count", count, 0);

      // 5. Flush with a full pipeline and an item offered
      drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'h66, 1'b0);
      drive(1'b1, 8'h77, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      check("fl_pre_count", count, 3);
      @(posedge clk);
      #1;
      flush = 1'b1; in_valid = 1'b1; d = 8'h99; out_ready = 1'b1;
      @(negedge clk);
      check("fl_in_ready", in_ready, 0);
      drive(1'b0, 8'h00, 1'b0);
      check("fl_count", count, 0);
      check("fl_ov", out_valid, 0);
      check("fl_q", q, 8'h00);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 8'h00, 1'b1);
         check("fl_no_capture_ov", out_valid, 0);
         check("fl_no_capture_count", count, 0);
      end

      // 6. Asynchronous reset mid-operation
      drive(1'b1, 8'h81, 1'b0);
      drive(1'b1, 8'h82, 1'b0);
      drive(1'b0, 8'h00, 1'b0);
      check("ar_pre_count", count, 2);
      #1 rest = 1'b0;
      #1;
      check("ar_now_ov", out_valid, 0);
      check("ar_now_count", count, 0);
      check("ar_now_q", q, 8'h00);
      check("ar_now_in_ready", in_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rest = 1'b1;
      @(negedge clk);
      check("ar_rel_ov", out_valid, 0);
      check("ar_rel_count", count, 0);
      check("ar_rel_in_ready", in_ready, 1);
      drive(1'b1, 8'hC3, 1'b1);
      drive(1'b0, 8'h00, 1'b1);
      check("ar_lat_c1_ov", out_valid, 0);
      drive(1'b0, 8'h00, 1'b1);
      check("ar_lat_c2_ov", out_valid, 0);
      drive(1'b0, 8'h00, 1'b1);
      check("ar_lat_c3_ov", out_valid, 1);
      check("ar_lat_c3_q", q, 8'hC3);
      drive(1'b0, 8'h00, 1'b1);
      check("ar_lat_c4_count", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
